johnson_step_ctrl: RTL and testbench



---
 rtl/johnson_step_ctrl.sv | 132 +++++++++++++
 tb/tb_johnson_step_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_step_ctrl.sv
// Sequencer for a 4-bit Johnson counter: runs a requested number of steps
// with optional tick division, hold and abort. JOHNSON_CHECK_EN enables illegal-load rejection.
module johnson_step_ctrl #(
  parameter int STEP_W   = 8,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              dir,
  input  logic [STEP_W-1:0] steps,
  input  logic              hold,
  input  logic              abort,
  input  logic              load_en,
  input  logic [3:0]        load_val,
  output logic [3:0]        q,
  output logic [2:0]        phase,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0]        TICK_LAST = 8'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] ONE_STEP  = STEP_W'(1);

  state_t            state;
  logic [STEP_W-1:0] remaining;
  logic [7:0]        presc;
  logic              run_dir;

  function automatic logic [3:0] step_code(input logic [3:0] c, input logic d);
    return d ? {c[2:0], ~c[3]} : {~c[0], c[3:1]};
  endfunction

`ifdef JOHNSON_CHECK_EN
  logic err_q;
  assign err = err_q;

  function automatic logic is_legal(input logic [3:0] c);
    logic ok;
    case (c)
      4'b0000, 4'b1000, 4'b1100, 4'b1110,
      4'b1111, 4'b0111, 4'b0011, 4'b0001: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction
`else
  assign err = 1'b0;
`endif

  always_comb begin
    phase = 3'd0;
    case (q)
      4'b1000: phase = 3'd1;
      4'b1100: phase = 3'd2;
      4'b1110: phase = 3'd3;
      4'b1111: phase = 3'd4;
      4'b0111: phase = 3'd5;
      4'b0011: phase = 3'd6;
      4'b0001: phase = 3'd7;
      default: phase = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      presc     <= 8'd0;
      run_dir   <= 1'b0;
`ifdef JOHNSON_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (steps != '0) begin
              remaining <= steps;
              run_dir   <= dir;
              presc     <= 8'd0;
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (load_en) begin
`ifdef JOHNSON_CHECK_EN
            if (is_legal(load_val)) q <= load_val;
            else                    err_q <= 1'b1;
`else
            q <= load_val;
`endif
          end
        end
        RUN: begin
          // abort outranks both hold and a pending step
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!hold) begin
            if (presc == TICK_LAST) begin
              presc     <= 8'd0;
              q         <= step_code(q, run_dir);
              remaining <= remaining - ONE_STEP;
              if (remaining == ONE_STEP) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              presc <= presc + 8'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Scoreboard bench for johnson_step_ctrl: one instance at TICK_DIV=1, one at TICK_DIV=4.
module tb_johnson_step_ctrl;

  typedef struct {
    int       cyc;
    logic [3:0] q;
    logic [2:0] ph;
    logic     busy;
    logic     is_done;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start4 = 1'b0, dir = 1'b0, hold = 1'b0, abort = 1'b0, load_en = 1'b0;
  logic [7:0] steps = 8'd0;
  logic [3:0] load_val = 4'd0;

  logic [3:0] q1, q4;
  logic [2:0] phase1, phase4;
  logic busy1, busy4, done1, done4, err1, err4;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  ev_t exp1[$];
  ev_t exp4[$];
  logic [3:0] prev_q1 = 4'd0, prev_q4 = 4'd0;
  logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                           4'b1111, 4'b0111, 4'b0011, 4'b0001};

  johnson_step_ctrl #(.STEP_W(8), .TICK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .steps(steps),
    .hold(hold), .abort(abort), .load_en(load_en), .load_val(load_val),
    .q(q1), .phase(phase1), .busy(busy1), .done(done1), .err(err1));

  johnson_step_ctrl #(.STEP_W(8), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dir(dir), .steps(steps),
    .hold(hold), .abort(abort), .load_en(1'b0), .load_val(4'b0000),
    .q(q4), .phase(phase4), .busy(busy4), .done(done4), .err(err4));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic checkEvent(input bit which, input bit is_done, input logic [3:0] qv,
                            input logic [2:0] ph, input logic bz);
    ev_t e;
    string tag;
    tag = which ? "dut4" : "dut1";
    if ((which ? exp4.size() : exp1.size()) == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s unexpected %s event: q=%b done=%0b, expected none (cycle %0d)",
               tag, is_done ? "done" : "q-change", qv, is_done, cyc);
      return;
    end
    e = which ? exp4.pop_front() : exp1.pop_front();
    checkOutput({tag, " kind"}, int'(is_done), int'(e.is_done));
    checkOutput({tag, " cycle"}, cyc, e.cyc);
    checkOutput({tag, " q"}, int'(qv), int'(e.q));
    checkOutput({tag, " phase"}, int'(ph), int'(e.ph));
    checkOutput({tag, " busy"}, int'(bz), int'(e.busy));
  endtask

  // Monitor: every q change and every done pulse is matched against the queues
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_q1 = 4'd0;
      prev_q4 = 4'd0;
    end else begin
      if (q1 !== prev_q1) checkEvent(1'b0, 1'b0, q1, phase1, busy1);
      if (done1)          checkEvent(1'b0, 1'b1, q1, phase1, busy1);
      if (q4 !== prev_q4) checkEvent(1'b1, 1'b0, q4, phase4, busy4);
      if (done4)          checkEvent(1'b1, 1'b1, q4, phase4, busy4);
      prev_q1 = q1;
      prev_q4 = q4;
    end
  end

  task automatic push(input bit which, input int c, input logic [3:0] qv,
                      input logic [2:0] ph, input logic bz, input logic dn);
    ev_t e;
    e.cyc = c; e.q = qv; e.ph = ph; e.busy = bz; e.is_done = dn;
    if (which) exp4.push_back(e);
    else       exp1.push_back(e);
  endtask

  // Expected steps from the legal-code table, followed by the done pulse
  task automatic pushRun(input bit which, input logic [3:0] from, input bit d,
                         input int n, input int e, input int t);
    int idx;
    idx = 0;
    for (int i = 0; i < 8; i++) if (codes[i] == from) idx = i;
    for (int k = 1; k <= n; k++) begin
      idx = d ? (idx + 7) % 8 : (idx + 1) % 8;
      push(which, e + k * t, codes[idx], 3'(idx), k != n, 1'b0);
    end
    push(which, e + n * t, codes[idx], 3'(idx), 1'b0, 1'b1);
  endtask

  task automatic applyStimulus(input bit which, input bit d, input int n, output int e);
    @(posedge clk); #1;
    if (which) start4 = 1'b1;
    else       start  = 1'b1;
    dir = d;
    steps = 8'(n);
    e = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic applyLoad(input logic [3:0] v, output int e);
    @(posedge clk); #1;
    load_en = 1'b1;
    load_val = v;
    e = cyc + 1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 200 && (exp1.size() != 0 || exp4.size() != 0); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drain dut1", exp1.size(), 0);
    checkOutput("drain dut4", exp4.size(), 0);
    exp1.delete();
    exp4.delete();
  endtask

  initial begin
    int e;
    #12;
    checkOutput("reset q", int'(q1), 0);
    checkOutput("reset phase", int'(phase1), 0);
    checkOutput("reset busy", int'(busy1), 0);
    checkOutput("reset done", int'(done1), 0);
    checkOutput("reset err", int'(err1), 0);
    checkOutput("reset q4", int'(q4), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full up lap
    applyStimulus(1'b0, 1'b0, 8, e);
    pushRun(1'b0, 4'b0000, 1'b0, 8, e, 1);
    waitDrain();

    // Load then three down steps
    applyLoad(4'b1111, e);
    push(1'b0, e, 4'b1111, 3'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 3, e);
    pushRun(1'b0, 4'b1111, 1'b1, 3, e, 1);
    waitDrain();
    checkOutput("q holds after run", int'(q1), 4'b1000);

    // Divided ticks with a three-cycle hold after the first step
    applyStimulus(1'b1, 1'b0, 2, e);
    push(1'b1, e + 4,  4'b1000, 3'd1, 1'b1, 1'b0);
    push(1'b1, e + 11, 4'b1100, 3'd2, 1'b0, 1'b0);
    push(1'b1, e + 11, 4'b1100, 3'd2, 1'b0, 1'b1);
    waitUntil(e + 4);
    hold = 1'b1;
    waitUntil(e + 7);
    hold = 1'b0;
    waitDrain();

    // Abort after two of five steps
    applyStimulus(1'b0, 1'b0, 5, e);
    push(1'b0, e + 1, 4'b1100, 3'd2, 1'b1, 1'b0);
    push(1'b0, e + 2, 4'b1110, 3'd3, 1'b1, 1'b0);
    waitUntil(e + 2);
    abort = 1'b1;
    waitUntil(e + 3);
    abort = 1'b0;
    checkOutput("abort busy", int'(busy1), 0);
    checkOutput("abort q", int'(q1), 4'b1110);
    waitDrain();

    // Zero-step start, then a start issued mid-run
    applyStimulus(1'b0, 1'b0, 0, e);
    push(1'b0, e, 4'b1110, 3'd3, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b0, 1'b0, 3, e);
    pushRun(1'b0, 4'b1110, 1'b0, 3, e, 1);
    start = 1'b1; dir = 1'b1; steps = 8'd1;
    @(posedge clk); #1;
    start = 1'b0; dir = 1'b0;
    waitDrain();

    // Illegal load
    applyLoad(4'b1010, e);
`ifdef JOHNSON_CHECK_EN
    checkOutput("illegal load q", int'(q1), 4'b0011);
    checkOutput("illegal load err", int'(err1), 1);
    applyStimulus(1'b0, 1'b0, 1, e);
    pushRun(1'b0, 4'b0011, 1'b0, 1, e, 1);
    waitDrain();
    checkOutput("err sticky", int'(err1), 1);
`else
    push(1'b0, e, 4'b1010, 3'd0, 1'b0, 1'b0);
    waitDrain();
    checkOutput("illegal load err", int'(err1), 0);
    applyStimulus(1'b0, 1'b0, 1, e);
    push(1'b0, e + 1, 4'b1101, 3'd0, 1'b0, 1'b0);
    push(1'b0, e + 1, 4'b1101, 3'd0, 1'b0, 1'b1);
    waitDrain();
`endif
    rst_n = 1'b0;
    #2;
    checkOutput("err after reset", int'(err1), 0);
    checkOutput("q after reset", int'(q1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
